// File: rtl/fwrisc_mds_issue.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_mds_issue
// Purpose  : Decodes RV32 OP-class mul/div/shift instructions, issues them to
//            the shared MDS unit and returns the result on a writeback port.
// Revision : 1.0
// ============================================================================
module fwrisc_mds_issue #(
  parameter bit          ENABLE_MUL     = 1'b1,
  parameter bit          ENABLE_DIV     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic [31:0] mds_in_a,
  output logic [31:0] mds_in_b,
  output logic [3:0]  mds_op,
  output logic        mds_in_valid,
  input  logic [31:0] mds_out,
  input  logic        mds_out_valid,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  localparam logic [3:0] c_op_sll   = 4'd0;
  localparam logic [3:0] c_op_srl   = 4'd1;
  localparam logic [3:0] c_op_sra   = 4'd2;
  localparam logic [3:0] c_op_mulh  = 4'd4;
  localparam logic [3:0] c_op_muls  = 4'd5;
  localparam logic [3:0] c_op_mulsh = 4'd6;
  localparam logic [3:0] c_op_div   = 4'd7;
  localparam logic [3:0] c_op_rem   = 4'd8;
  localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_count;

  logic [3:0]  w_op;
  logic        w_illegal;
  logic        w_shift;
  logic        w_div;
  logic        w_rem;
  logic        w_local;
  logic [31:0] w_local_data;

  always_comb begin
    w_op      = c_op_sll;
    w_illegal = 1'b1;
    w_shift   = 1'b0;
    w_div     = 1'b0;
    w_rem     = 1'b0;
    case (req_funct7)
      7'b0000001: begin
        case (req_funct3)
          3'd0: begin w_op = c_op_muls;  w_illegal = !ENABLE_MUL; end
          3'd1: begin w_op = c_op_mulsh; w_illegal = !ENABLE_MUL; end
          3'd3: begin w_op = c_op_mulh;  w_illegal = !ENABLE_MUL; end
          3'd4: begin w_op = c_op_div;   w_illegal = !ENABLE_DIV; w_div = 1'b1; end
          3'd6: begin w_op = c_op_rem;   w_illegal = !ENABLE_DIV; w_rem = 1'b1; end
          default: ;
        endcase
      end
      7'b0000000: begin
        if (req_funct3 == 3'd1) begin
          w_op = c_op_sll; w_illegal = 1'b0; w_shift = 1'b1;
        end else if (req_funct3 == 3'd5) begin
          w_op = c_op_srl; w_illegal = 1'b0; w_shift = 1'b1;
        end
      end
      7'b0100000: begin
        if (req_funct3 == 3'd5) begin
          w_op = c_op_sra; w_illegal = 1'b0; w_shift = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Results known without the unit: illegal, zero shift, divide by zero
  assign w_local = w_illegal
                 | (w_shift & (req_rs2[4:0] == 5'd0))
                 | ((w_div | w_rem) & (req_rs2 == 32'd0));
  assign w_local_data = w_illegal ? 32'd0 : (w_div ? 32'hFFFF_FFFF : req_rs1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_count      <= 8'd0;
      req_ready    <= 1'b1;
      mds_in_valid <= 1'b0;
      mds_in_a     <= 32'd0;
      mds_in_b     <= 32'd0;
      mds_op       <= 4'd0;
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      wb_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            wb_rd     <= req_rd;
            if (w_local) begin
              wb_data  <= w_local_data;
              wb_err   <= w_illegal;
              wb_valid <= 1'b1;
              r_state  <= S_WB;
            end else begin
              mds_in_a     <= req_rs1;
              mds_in_b     <= req_rs2;
              mds_op       <= w_op;
              mds_in_valid <= 1'b1;
              r_state      <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          mds_in_valid <= 1'b0;
          r_count      <= 8'd0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_count <= r_count + 8'd1;
          // A result arriving on the last allowed cycle beats the timeout
          if (mds_out_valid) begin
            wb_data  <= mds_out;
            wb_err   <= 1'b0;
            wb_valid <= 1'b1;
            r_state  <= S_WB;
          end else if (r_count == c_timeout_last) begin
            wb_data  <= 32'd0;
            wb_err   <= 1'b1;
            wb_valid <= 1'b1;
            r_state  <= S_WB;
          end
        end
        S_WB: begin
          if (wb_ready) begin
            wb_valid  <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
